// File: rtl/cam_fb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cam_fb_pkg
// Brief    : Shared frame-buffer luma constants and the reader state encoding.
// Revision : 1.0
// ============================================================================
package cam_fb_pkg;

    localparam int FB_Y_WORD_W    = 40;
    localparam int FB_SPW         = 5;
    localparam int FB_ADDR_W      = 16;
    localparam int FB_FRAME_WORDS = 61440;
    localparam int FB_RD_LAT      = 2;
    localparam int FB_FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fb_word_fifo
// Brief    : Synchronous word FIFO with occupancy count; head word is shown
//            combinationally on rdata whenever the FIFO is not empty.
// Revision : 1.0
// ============================================================================
module fb_word_fifo #(
    parameter  int WORD_W = 40,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_wr_en;
    logic              w_rd_en;

    assign full    = (r_count == c_DEPTH);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rdata   = r_mem[r_rd_ptr];
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_luma_reader.sv
`default_nettype none
// ============================================================================
// Module   : fb_luma_reader
// Brief    : Reads one frame of packed luma words and streams one Y sample per
//            beat over valid/ready. Define LUMA_CHECKSUM_EN for a per-frame
//            16-bit sample checksum output.
// Revision : 1.0
// ============================================================================
module fb_luma_reader
    import cam_fb_pkg::*;
#(
    parameter int WORD_W      = FB_Y_WORD_W,
    parameter int SPW         = FB_SPW,
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int FRAME_WORDS = FB_FRAME_WORDS,
    parameter int RD_LAT      = FB_RD_LAT,
    parameter int FIFO_DEPTH  = FB_FIFO_DEPTH
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic [WORD_W-1:0] q,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof
`ifdef LUMA_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int SAMP_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W  = $clog2(RD_LAT + 1);
    localparam int USED_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [SAMP_W-1:0] c_LAST_SAMP = SAMP_W'(SPW - 1);
    localparam logic [USED_W-1:0] c_DEPTH     = USED_W'(FIFO_DEPTH);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_out_word;
    logic [SAMP_W-1:0] r_samp;
    logic [RD_LAT-1:0] r_vld;
    logic [LAT_W-1:0]  w_in_flight;
    logic [USED_W-1:0] w_used;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [WORD_W-1:0] w_head;
    logic [7:0]        w_samples [SPW];
    logic              w_start_acc;
    logic              w_credit_ok;
    logic              w_rden;
    logic              w_push;
    logic              w_accept;
    logic              w_last_samp;
    logic              w_last_word;
    logic              w_pop;
    logic              w_frame_end;

    // Credit = words already buffered plus words still inside the RAM pipeline.
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_in_flight = w_in_flight + LAT_W'(r_vld[i]);
        end
    end

    assign w_used      = USED_W'(w_fifo_count) + USED_W'(w_in_flight);
    assign w_credit_ok = (w_used < c_DEPTH);
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_push      = r_vld[RD_LAT-1];
    assign w_accept    = !w_fifo_empty && out_ready;
    assign w_last_samp = (r_samp == c_LAST_SAMP);
    assign w_last_word = (r_out_word == c_LAST_ADDR);
    assign w_pop       = w_accept && w_last_samp;
    assign w_frame_end = w_pop && w_last_word;

    always_comb begin
        w_state_nxt = r_state;
        w_rden      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_rden = w_credit_ok;
                if (w_credit_ok && (r_rd_addr == c_LAST_ADDR)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_frame_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_rd_addr <= '0;
        end else if (w_start_acc) begin
            r_rd_addr <= '0;
        end else if (w_rden && (r_rd_addr != c_LAST_ADDR)) begin
            r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat_one
            always_ff @(posedge CLOCK_50) begin
                if (RESET) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= w_rden;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge CLOCK_50) begin
                if (RESET) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= {r_vld[RD_LAT-2:0], w_rden};
                end
            end
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (!RESET) begin
            assert (!(w_push && w_fifo_full));
        end
    end

    fb_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .push  (w_push),
        .wdata (q),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    generate
        for (genvar gi = 0; gi < SPW; gi++) begin : g_unpack
            assign w_samples[gi] = w_head[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_samp     <= '0;
            r_out_word <= '0;
        end else if (w_start_acc) begin
            r_samp     <= '0;
            r_out_word <= '0;
        end else if (w_accept) begin
            if (w_last_samp) begin
                r_samp <= '0;
                if (!w_last_word) begin
                    r_out_word <= r_out_word + 1'b1;
                end
            end else begin
                r_samp <= r_samp + 1'b1;
            end
        end
    end

    assign rden      = w_rden;
    assign rdaddress = r_rd_addr;
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_samples[r_samp];
    assign out_sof   = out_valid && (r_out_word == '0) && (r_samp == '0);
    assign out_eof   = out_valid && w_last_word && w_last_samp;

`ifdef LUMA_CHECKSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_csum <= '0;
        end else if (w_start_acc) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= r_csum + 16'(out_data);
        end
    end

    assign checksum = r_csum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_luma_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_luma_reader
// Brief    : Self-checking bench for fb_luma_reader using a reduced frame size,
//            a latency-accurate RAM model and a sample-stream reference model.
// Revision : 1.0
// ============================================================================
module tb_fb_luma_reader;

    localparam int WORD_W = 40;
    localparam int SPW    = 5;
    localparam int ADDR_W = 16;
    localparam int FW     = 16;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;
    localparam int TOTAL  = FW * SPW;
    localparam int BUDGET = TOTAL * 4 + 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rdaddress;
    logic              rden;
    logic [WORD_W-1:0] q;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;
`ifdef LUMA_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    always #5 clk = ~clk;

    fb_luma_reader #(
        .WORD_W      (WORD_W),
        .SPW         (SPW),
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FW),
        .RD_LAT      (RD_LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
`ifdef LUMA_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // Frame-buffer model: data appears on q exactly two cycles after rden.
    logic [WORD_W-1:0] mem [FW];
    logic [WORD_W-1:0] ram_p1;

    always @(posedge clk) begin
        if (rden && (int'(rdaddress) < FW)) ram_p1 <= mem[rdaddress];
        else                                ram_p1 <= {$urandom(), 8'hE7};
        q <= ram_p1;
    end

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int issued, acc_cnt, credit_viol, stall_viol, done_cnt;
    int first_rden_cyc, first_valid_cyc;
    logic [7:0] got [$];
    bit         sof_q [$];
    bit         eof_q [$];
    logic [7:0] first_stream [$];
    logic       prev_stall;
    logic [7:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rden) begin
                if (issued - acc_cnt / SPW >= DEPTH) credit_viol++;
                if (first_rden_cyc < 0) first_rden_cyc = cyc;
                issued++;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                sof_q.push_back(out_sof);
                eof_q.push_back(out_eof);
                acc_cnt++;
            end
            if (done) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        issued = 0; acc_cnt = 0; credit_viol = 0; stall_viol = 0; done_cnt = 0;
        first_rden_cyc = -1; first_valid_cyc = -1; prev_stall = 1'b0;
        got.delete(); sof_q.delete(); eof_q.delete();
    endtask

    // mode 0: byte k of word a = 5a+k; mode 1: all 0xFF; mode 2: random.
    task automatic fill_mem(input int mode);
        logic [WORD_W-1:0] w;
        for (int a = 0; a < FW; a++) begin
            for (int k = 0; k < SPW; k++) begin
                case (mode)
                    0:       w[8*k +: 8] = 8'(a * SPW + k);
                    1:       w[8*k +: 8] = 8'hFF;
                    default: w[8*k +: 8] = 8'($urandom_range(0, 255));
                endcase
            end
            mem[a] = w;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [7:0] exp_sample(input int i);
        logic [WORD_W-1:0] w;
        w = mem[i / SPW];
        return w[8*(i % SPW) +: 8];
    endfunction

    // First index where the accepted stream departs from the frame contents, -1 if none.
    function automatic int seq_err();
        if (got.size() != TOTAL) return (got.size() < TOTAL) ? got.size() : TOTAL;
        for (int i = 0; i < TOTAL; i++) if (got[i] !== exp_sample(i)) return i;
        return -1;
    endfunction

    // Index of the single flagged sample, or -1 if zero or several are flagged.
    function automatic int only_flag(input bit want_eof);
        int n, pos;
        n = 0; pos = -1;
        for (int i = 0; i < got.size(); i++) begin
            if ((want_eof ? eof_q[i] : sof_q[i]) == 1'b1) begin
                n++; pos = i;
            end
        end
        return (n == 1) ? pos : -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (rden !== 1'b0)       begin n_err++; $display("FAIL reset_rden got %b want 0", rden); end
        n_cmp++; if (rdaddress !== '0)    begin n_err++; $display("FAIL reset_addr got %0d want 0", rdaddress); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if ({out_sof, out_eof} !== 2'b00) begin n_err++; $display("FAIL reset_sof_eof got %b want 00", {out_sof, out_eof}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_frame();
        int e;
        fill_mem(0);
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy got %b want 1", busy); end
        for (int i = 0; i < BUDGET && done_cnt == 0; i++) tick();
        repeat (5) tick();
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL first_done_count got %0d want 1", done_cnt); end
        n_cmp++;
        if (first_valid_cyc - first_rden_cyc != RD_LAT + 1) begin
            n_err++; $display("FAIL first_latency got %0d want %0d", first_valid_cyc - first_rden_cyc, RD_LAT + 1);
        end
        n_cmp++;
        if (got.size() < 5 || {got[4], got[3], got[2], got[1], got[0]} !== 40'h04_03_02_01_00) begin
            n_err++; $display("FAIL first_word_order got %0d samples, first five not 00..04", got.size());
        end
        e = seq_err();
        n_cmp++; if (e != -1) begin n_err++; $display("FAIL first_sequence bad index %0d want -1", e); end
        n_cmp++; if (only_flag(1'b0) != 0) begin n_err++; $display("FAIL first_sof got index %0d want 0", only_flag(1'b0)); end
        n_cmp++; if (only_flag(1'b1) != TOTAL - 1) begin n_err++; $display("FAIL first_eof got index %0d want %0d", only_flag(1'b1), TOTAL - 1); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL first_idle_busy got %b want 0", busy); end
        first_stream = got;
    endtask

    task automatic test_random_ready();
        int bad;
        fill_mem(0);
        clear_mon();
        pulse_start();
        for (int i = 0; i < BUDGET * 2 && done_cnt == 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        repeat (5) tick();
        bad = (got.size() == first_stream.size()) ? 0 : 1;
        for (int i = 0; i < got.size() && i < first_stream.size(); i++) if (got[i] !== first_stream[i]) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rand_same_stream got %0d differences want 0", bad); end
        n_cmp++; if (credit_viol != 0) begin n_err++; $display("FAIL rand_credit got %0d over-credit reads want 0", credit_viol); end
        n_cmp++; if (stall_viol != 0) begin n_err++; $display("FAIL rand_hold got %0d unstable stalls want 0", stall_viol); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rand_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        int e;
        fill_mem(2);
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < BUDGET && acc_cnt < 12; i++) tick();
        out_ready = 1'b0;
        repeat (20) tick();
        n_cmp++; if (rden !== 1'b0) begin n_err++; $display("FAIL stall_rden got %b want 0", rden); end
        n_cmp++;
        if (issued - acc_cnt / SPW != DEPTH) begin
            n_err++; $display("FAIL stall_words_held got %0d want %0d", issued - acc_cnt / SPW, DEPTH);
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b want 1", out_valid); end
        n_cmp++; if (stall_viol != 0) begin n_err++; $display("FAIL stall_hold got %0d unstable stalls want 0", stall_viol); end
        out_ready = 1'b1;
        for (int i = 0; i < BUDGET && done_cnt == 0; i++) tick();
        repeat (3) tick();
        e = seq_err();
        n_cmp++; if (e != -1) begin n_err++; $display("FAIL stall_sequence bad index %0d want -1", e); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_inflight();
        int e;
        fill_mem(2);
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if ({busy, done, rden} !== 3'b000) begin n_err++; $display("FAIL rst_flight_ctrl got %b want 000", {busy, done, rden}); end
        n_cmp++; if (rdaddress !== '0) begin n_err++; $display("FAIL rst_flight_addr got %0d want 0", rdaddress); end
        n_cmp++; if ({out_valid, out_sof, out_eof} !== 3'b000) begin n_err++; $display("FAIL rst_flight_out got %b want 000", {out_valid, out_sof, out_eof}); end
        rst = 1'b0;
        clear_mon();
        repeat (6) tick();
        n_cmp++;
        if (first_valid_cyc != -1 || acc_cnt != 0 || issued != 0) begin
            n_err++; $display("FAIL rst_flight_discard got valid_cyc=%0d acc=%0d reads=%0d want -1/0/0", first_valid_cyc, acc_cnt, issued);
        end
        fill_mem(2);
        clear_mon();
        pulse_start();
        n_cmp++; if ({rden, rdaddress} !== {1'b1, 16'd0}) begin n_err++; $display("FAIL rst_restart_addr got rden=%b addr=%0d want 1/0", rden, rdaddress); end
        for (int i = 0; i < BUDGET && done_cnt == 0; i++) tick();
        repeat (3) tick();
        e = seq_err();
        n_cmp++; if (e != -1) begin n_err++; $display("FAIL rst_restart_sequence bad index %0d want -1", e); end
    endtask

    task automatic test_start_busy();
        int e;
        fill_mem(2);
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        repeat (10) tick();
        pulse_start();
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (done === 1'b1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                break;
            end
        end
        repeat (10) tick();
        e = seq_err();
        n_cmp++; if (acc_cnt != TOTAL) begin n_err++; $display("FAIL busy_sample_count got %0d want %0d", acc_cnt, TOTAL); end
        n_cmp++; if (e != -1) begin n_err++; $display("FAIL busy_sequence bad index %0d want -1", e); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (issued != FW) begin n_err++; $display("FAIL busy_read_count got %0d want %0d", issued, FW); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done got %b want 0", busy); end
    endtask

`ifdef LUMA_CHECKSUM_EN
    task automatic test_checksum();
        logic [15:0] exp_sum;
        exp_sum = 16'((TOTAL * 255) % 65536);
        fill_mem(1);
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        n_cmp++; if (checksum !== 16'h0) begin n_err++; $display("FAIL csum_clear got %h want 0000", checksum); end
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (done === 1'b1) break;
        end
        n_cmp++; if (checksum !== exp_sum) begin n_err++; $display("FAIL csum_at_done got %h want %h", checksum, exp_sum); end
        repeat (5) tick();
        n_cmp++; if (checksum !== exp_sum) begin n_err++; $display("FAIL csum_hold got %h want %h", checksum, exp_sum); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        clear_mon();
        test_reset();
        test_first_frame();
        test_random_ready();
        test_stall();
        test_reset_inflight();
        test_start_busy();
`ifdef LUMA_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
